// File: rtl/ror_shift_arbiter.sv
// Round-robin arbiter that shares one 4-bit rotate-right unit among NREQ clients.
// The winner's result is held in a one-entry valid/ready output register, tagged with its index.

module ror4 (
    input  logic [3:0] a_i,
    input  logic [1:0] amt_i,
    output logic [3:0] y_o
);
    always_comb begin
        case (amt_i)
            2'd0:    y_o = a_i;
            2'd1:    y_o = {a_i[0],   a_i[3:1]};
            2'd2:    y_o = {a_i[1:0], a_i[3:2]};
            default: y_o = {a_i[2:0], a_i[3]};
        endcase
    end
endmodule

module ror_shift_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [4*NREQ-1:0]        a_i,
    input  logic [2*NREQ-1:0]        amt_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [3:0]               y_o,
    output logic [$clog2(NREQ)-1:0]  id_o,
    output logic                     vld_o,
    input  logic                     rdy_i
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [3:0]      y_q, y_d;

    logic            acc;
    logic            found;
    logic [IDW-1:0]  idx;
    logic [IDW-1:0]  win;
    logic [3:0]      a_sel;
    logic [1:0]      amt_sel;
    logic [3:0]      rot_y;
    logic [NREQ-1:0] gnt;

    // Search starts at ptr and wraps, so the first requester found is the round-robin winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr_q) + i) % NREQ);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        a_sel   = '0;
        amt_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win == IDW'(k)) begin
                a_sel   = a_i[4*k +: 4];
                amt_sel = amt_i[2*k +: 2];
            end
        end
    end

    ror4 u_ror (
        .a_i   (a_sel),
        .amt_i (amt_sel),
        .y_o   (rot_y)
    );

    assign acc = (state_q == EMPTY) || rdy_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        y_d     = y_q;
        id_d    = id_q;
        gnt     = '0;
        if (acc && found && !rst_i) begin
            gnt     = NREQ'(1) << win;
            state_d = FULL;
            ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
            y_d     = rot_y;
            id_d    = win;
        end else if (state_q == FULL && rdy_i) begin
            // Drained with nothing new to capture; y/id keep their stale values.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            y_q     <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            y_q     <= y_d;
            id_q    <= id_d;
        end
    end

    assign gnt_o = gnt;
    assign y_o   = y_q;
    assign id_o  = id_q;
    assign vld_o = (state_q == FULL);

endmodule

// File: tb/tb_ror_shift_arbiter.sv
// Self-checking bench for ror_shift_arbiter: directed vectors with literal expectations,
// plus a per-cycle comparison against an arithmetic reference model.

module tb_ror_shift_arbiter;
    localparam int N = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [N-1:0]  req_i;
    logic [4*N-1:0] a_i;
    logic [2*N-1:0] amt_i;
    logic [N-1:0]  gnt_o;
    logic [3:0]    y_o;
    logic [1:0]    id_o;
    logic          vld_o;
    logic          rdy_i;

    int checks   = 0;
    int failures = 0;

    ror_shift_arbiter #(.NREQ(N)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req_i),
        .a_i   (a_i),
        .amt_i (amt_i),
        .gnt_o (gnt_o),
        .y_o   (y_o),
        .id_o  (id_o),
        .vld_o (vld_o),
        .rdy_i (rdy_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [N-1:0] rq,
                                 input logic [4*N-1:0] a, input logic [2*N-1:0] amt,
                                 input logic rd);
        @(posedge clk_i);
        #1;
        rst_i = r;
        req_i = rq;
        a_i   = a;
        amt_i = amt;
        rdy_i = rd;
    endtask

    function automatic int ror_model(input int a, input int n);
        return ((a >> n) | (a << (4 - n))) & 15;
    endfunction

    // Reference model: output register contents and round-robin pointer as plain integers.
    bit model_on = 1'b0;
    int m_vld, m_y, m_id, m_ptr;

    always @(negedge clk_i) begin
        int exp_gnt;
        int w;
        exp_gnt = 0;
        w = -1;
        if (!rst_i && (m_vld == 0 || rdy_i)) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (w < 0 && req_i[c]) w = c;
            end
            if (w >= 0) exp_gnt = 1 << w;
        end
        if (model_on) begin
            checkOutput("model_gnt", int'(gnt_o), exp_gnt);
            checkOutput("model_vld", int'(vld_o), m_vld);
            if (m_vld != 0) begin
                checkOutput("model_y", int'(y_o), m_y);
                checkOutput("model_id", int'(id_o), m_id);
            end
        end
        if (rst_i) begin
            model_on = 1'b1;
            m_vld = 0; m_y = 0; m_id = 0; m_ptr = 0;
        end else if (w >= 0) begin
            m_vld = 1;
            m_y   = ror_model(int'(a_i[4*w +: 4]), int'(amt_i[2*w +: 2]));
            m_id  = w;
            m_ptr = (w + 1) % N;
        end else if (m_vld != 0 && rdy_i) begin
            m_vld = 0;
        end
    end

    initial begin
        logic [N-1:0] last_gnt;
        logic [3:0]   exp_y [4];
        exp_y[0] = 4'b1001; exp_y[1] = 4'b1100; exp_y[2] = 4'b0110; exp_y[3] = 4'b0011;

        rst_i = 1'b1; req_i = '0; a_i = '0; amt_i = '0; rdy_i = 1'b0;

        // Reset with all requesting: no grant may escape.
        applyStimulus(1, 4'b1111, 16'h0000, 8'h00, 1);
        @(negedge clk_i);
        checkOutput("rst_vld", int'(vld_o), 0);
        checkOutput("rst_y", int'(y_o), 0);
        checkOutput("rst_id", int'(id_o), 0);
        checkOutput("rst_gnt", int'(gnt_o), 0);

        // Single request, latency and drain.
        applyStimulus(0, 4'b0001, 16'h0009, 8'h01, 1);
        @(negedge clk_i);
        checkOutput("single_gnt", int'(gnt_o), 1);
        applyStimulus(0, 4'b0000, 16'h0000, 8'h00, 1);
        @(negedge clk_i);
        checkOutput("single_vld", int'(vld_o), 1);
        checkOutput("single_y", int'(y_o), 12);
        checkOutput("single_id", int'(id_o), 0);
        applyStimulus(0, 4'b0000, 16'h0000, 8'h00, 1);
        @(negedge clk_i);
        checkOutput("single_drain_vld", int'(vld_o), 0);

        // Requester 2 through all rotate amounts, back to back.
        for (int n = 0; n < 4; n++) begin
            applyStimulus(0, 4'b0100, 16'h0900, 8'(n << 4), 1);
            @(negedge clk_i);
            checkOutput("amt_gnt", int'(gnt_o), 4);
            if (n > 0) begin
                checkOutput("amt_y", int'(y_o), int'(exp_y[n-1]));
                checkOutput("amt_id", int'(id_o), 2);
            end
        end
        applyStimulus(0, 4'b0000, 16'h0000, 8'h00, 1);
        @(negedge clk_i);
        checkOutput("amt_y_last", int'(y_o), 3);
        checkOutput("amt_vld_last", int'(vld_o), 1);

        // Round-robin rotation from a fresh pointer.
        applyStimulus(1, 4'b0000, 16'h0000, 8'h00, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 4'b1111, 16'h4321, 8'h00, 1);
            @(negedge clk_i);
            checkOutput("rr_gnt", int'(gnt_o), 1 << (i % 4));
            if (i > 0) checkOutput("rr_id", int'(id_o), (i - 1) % 4);
        end

        // Backpressure with requester 1 result held.
        applyStimulus(0, 4'b0010, 16'h0060, 8'h00, 1);
        @(negedge clk_i);
        checkOutput("bp_gnt1", int'(gnt_o), 2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 4'b0101, 16'h0A05, 8'h00, 0);
            @(negedge clk_i);
            checkOutput("bp_vld", int'(vld_o), 1);
            checkOutput("bp_y", int'(y_o), 6);
            checkOutput("bp_id", int'(id_o), 1);
            checkOutput("bp_gnt", int'(gnt_o), 0);
        end
        applyStimulus(0, 4'b0101, 16'h0A05, 8'h00, 1);
        @(negedge clk_i);
        checkOutput("bp_release_gnt", int'(gnt_o), 4);

        // Pointer wrap from requester 3 back to 0.
        applyStimulus(0, 4'b1001, 16'h7005, 8'h00, 1);
        @(negedge clk_i);
        checkOutput("wrap_gnt3", int'(gnt_o), 8);
        applyStimulus(0, 4'b1001, 16'h7005, 8'h00, 1);
        @(negedge clk_i);
        checkOutput("wrap_gnt0", int'(gnt_o), 1);
        applyStimulus(0, 4'b1001, 16'h7005, 8'h00, 1);
        @(negedge clk_i);
        checkOutput("wrap_gnt3b", int'(gnt_o), 8);

        // Reset while a result is held.
        applyStimulus(0, 4'b0000, 16'h0000, 8'h00, 0);
        @(negedge clk_i);
        checkOutput("mid_vld_before", int'(vld_o), 1);
        applyStimulus(1, 4'b1111, 16'h0000, 8'h00, 0);
        @(negedge clk_i);
        checkOutput("mid_rst_gnt", int'(gnt_o), 0);
        applyStimulus(0, 4'b1111, 16'h0000, 8'h00, 1);
        @(negedge clk_i);
        checkOutput("mid_vld", int'(vld_o), 0);
        checkOutput("mid_y", int'(y_o), 0);
        checkOutput("mid_gnt", int'(gnt_o), 1);
        last_gnt = gnt_o;

        // Protocol-respecting random traffic checked by the model.
        for (int c = 0; c < 300; c++) begin
            @(posedge clk_i);
            #1;
            for (int k = 0; k < N; k++) begin
                if (!req_i[k] || last_gnt[k]) begin
                    req_i[k]          = 1'($urandom_range(0, 1));
                    a_i[4*k +: 4]     = 4'($urandom_range(0, 15));
                    amt_i[2*k +: 2]   = 2'($urandom_range(0, 3));
                end
            end
            rdy_i = ($urandom_range(0, 3) != 0);
            @(negedge clk_i);
            last_gnt = gnt_o;
        end

        applyStimulus(0, 4'b0000, 16'h0000, 8'h00, 1);
        applyStimulus(0, 4'b0000, 16'h0000, 8'h00, 1);
        @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ror_shift_arbiter.md
Name: ror_shift_arbiter

Overview:
- Shares a single 4-bit rotate-right unit among NREQ requesters.
- Round-robin arbitration with per-requester request/grant.
- Registered result, tagged with the requester index, held under consumer backpressure (valid/ready).
- Sits between client datapaths and the shared rotator; the rotator is instantiated inside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester-index tag (derived; not overridden).

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- req_i  input  NREQ  per-requester request; bit k belongs to requester k.
- a_i  input  4*NREQ  operands; requester k drives bits [4k+3:4k].
- amt_i  input  2*NREQ  rotate amounts; requester k drives bits [2k+1:2k].
- gnt_o  output  NREQ  one-hot grant; operands of the granted requester are captured this cycle.
- y_o  output  4  rotate-right result.
- id_o  output  IDW  index of the requester that owns y_o.
- vld_o  output  1  y_o/id_o valid.
- rdy_i  input  1  consumer accepts result when vld_o && rdy_i.

Behaviour:
- Reset: synchronous, active-high, 1 cycle.
  - vld_o=0, y_o=0, id_o=0, gnt_o=0.
  - Round-robin pointer = 0, so requester 0 has highest priority after reset.
- Result path is a one-entry output register; FSM states are EMPTY and FULL.
- Accept condition: acc = (state==EMPTY) || (vld_o && rdy_i).
- Grant (combinational):
  - When acc and req_i!=0, gnt_o is one-hot for the winner.
  - Otherwise gnt_o=0.
  - gnt_o never asserts while rst_i=1.
- Round-robin arbitration:
  - Search order starts at ptr and wraps modulo NREQ.
  - After a grant to k, ptr = (k+1) mod NREQ; NREQ-1 wraps to 0.
  - ptr is unchanged when there is no grant.
- Capture on a grant to k:
  - At the clock edge, y_o = ROR(a_k, amt_k), id_o=k, vld_o=1; state goes to FULL.
  - Latency: grant cycle N → vld_o=1 in cycle N+1.
- ROR(a, n):
  - n=0 → a.
  - n=1 → {a[0],a[3:1]}.
  - n=2 → {a[1:0],a[3:2]}.
  - n=3 → {a[2:0],a[3]}.
- FULL with rdy_i=0: y_o, id_o and vld_o hold stable; no grant is issued.
- FULL with rdy_i=1:
  - If there is a request: the result is consumed and the new winner is captured in the same edge; vld_o stays 1. Sustained throughput is 1 op/cycle.
  - If there is no request: vld_o→0, state→EMPTY. y_o and id_o keep their last values (don't-care while vld_o=0).
- Requester protocol:
  - Requester k holds req/a/amt stable until it sees gnt_o[k]=1.
  - It may drop req in the cycle after the grant. A still-asserted req counts as a new request.
  - A requester must not deassert req before it is granted.
- Fairness: with all requesters continuously requesting and rdy_i=1, grants rotate 0,1,…,NREQ-1,0…; no requester waits more than NREQ accept opportunities.
- Reset mid-operation: a held result is discarded (vld_o=0 next cycle) and ptr returns to 0. Any grant issued in the reset cycle is void because gnt_o is forced to 0.
- id_o is only meaningful when vld_o=1.

Test Plan:
- Reset, then single request: req_i=0001, a_0=1001, amt_0=01, rdy_i=1 → gnt_o=0001 in cycle N; cycle N+1 vld_o=1, y_o=1100, id_o=0; cycle N+2 vld_o=0.
- Rotate amounts: requester 2, a=1001, amt 00/01/10/11 in sequence → y_o=1001,1100,0110,0011 with id_o=2; throughput is one result per cycle under rdy_i=1.
- Round-robin: req_i=1111 held, rdy_i=1 → gnt_o sequence 0001,0010,0100,1000,0001; id_o lags the grant by one cycle.
- Backpressure: requester 1 result y_o=0110 valid, then rdy_i=0 for 3 cycles while req_i=0101 → y_o, id_o, vld_o stable and gnt_o=0. When rdy_i=1, the grant goes to requester 2 (ptr=2) on that same cycle.
- Pointer wrap: after a grant to requester 3, req_i=1001 → next grant to requester 0, then requester 3.
- Reset mid-operation: vld_o=1 with rdy_i=0, assert rst_i for 1 cycle → next cycle vld_o=0, y_o=0. With req_i=1111 the first grant after reset is 0001.
